// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// signed operands handled as magnitudes with a final sign-correction step.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_p_hi;
    logic [WIDTH-1:0] r_p_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_a_mag  = (sgn && a[WIDTH-1]) ? (-a) : a;
    assign w_b_mag  = (sgn && b[WIDTH-1]) ? (-b) : b;
    assign w_b_zero = (b == {WIDTH{1'b0}});

    // One shift-add step: the low half doubles as the multiplier shift register.
    assign w_mul_sum = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Restoring divide step; the difference always fits WIDTH bits when taken.
    assign w_div_shift = {r_p_hi, r_p_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
    assign w_div_rem   = w_div_shift[WIDTH-1:0] - r_m;

    assign w_prod     = {r_p_hi, r_p_lo};
    assign w_prod_fix = r_neg_q ? (-w_prod) : w_prod;

    // Sign correction of the finished magnitude result.
    always_comb begin
        w_fix_hi = r_hi;
        w_fix_lo = r_lo;
        if (r_op) begin
            w_fix_lo = r_neg_q ? (-r_p_lo) : r_p_lo;
            w_fix_hi = r_neg_r ? (-r_p_hi) : r_p_hi;
        end else begin
            w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    // Next-state logic; flush only aborts RUN and FIX.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (op && w_b_zero) ? S_DONE : S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == {CW{1'b0}}) begin
                    w_next_state = S_FIX;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_FIX:   w_next_state = flush ? S_IDLE : S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs; done lags the DONE state by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_op    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_m     <= {WIDTH{1'b0}};
            r_p_hi  <= {WIDTH{1'b0}};
            r_p_lo  <= {WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= sgn & a[WIDTH-1];
                        r_dz    <= op & w_b_zero;
                        r_m     <= w_b_mag;
                        r_p_hi  <= {WIDTH{1'b0}};
                        r_p_lo  <= w_a_mag;
                        r_cnt   <= CW'(WIDTH - 1);
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                        if (r_op) begin
                            r_p_hi <= w_div_ge ? w_div_rem : w_div_shift[WIDTH-1:0];
                            r_p_lo <= {r_p_lo[WIDTH-2:0], w_div_ge};
                        end else begin
                            r_p_hi <= w_mul_sum[WIDTH:1];
                            r_p_lo <= {w_mul_sum[0], r_p_lo[WIDTH-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                end
                S_DONE:  r_div0 <= r_dz;
                default: r_div0 <= r_div0;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign div0 = r_div0;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: WIDTH=32 and WIDTH=8 instances, hand-computed results.
module tb_md_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset32, start32, op32, sgn32, flush32;
    logic [31:0] a32, b32;
    logic        busy32, done32, div0_32;
    logic [31:0] hi32, lo32;

    logic        reset8, start8, op8, sgn8, flush8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, div0_8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    md_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset32), .start(start32), .op(op32), .sgn(sgn32),
        .a(a32), .b(b32), .flush(flush32), .busy(busy32), .done(done32),
        .div0(div0_32), .hi(hi32), .lo(lo32)
    );

    md_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .op(op8), .sgn(sgn8),
        .a(a8), .b(b8), .flush(flush8), .busy(busy8), .done(done8),
        .div0(div0_8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 32-bit unit; returns at the negedge of the done cycle.
    task automatic go32(input logic o, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, output int lat);
        @(negedge clk);
        op32 = o; sgn32 = s; a32 = av; b32 = bv; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        chk("busy_after_start", busy32, 1);
        lat = 0;
        while (!done32 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int ndone;

    initial begin
        reset32 = 1'b1; start32 = 1'b0; op32 = 1'b0; sgn32 = 1'b0; flush32 = 1'b0;
        a32 = 32'd0; b32 = 32'd0;
        reset8 = 1'b1; start8 = 1'b0; op8 = 1'b0; sgn8 = 1'b0; flush8 = 1'b0;
        a8 = 8'd0; b8 = 8'd0;
        repeat (3) @(negedge clk);
        reset32 = 1'b0; reset8 = 1'b0;
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_div0", div0_32, 0);
        chk("rst_hi", hi32, 0);
        chk("rst_lo", lo32, 0);

        // Unsigned max * max
        go32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("umul_lat", lat, 34);
        chk("umul_hi", hi32, 32'hFFFF_FFFE);
        chk("umul_lo", lo32, 32'h0000_0001);
        chk("umul_div0", div0_32, 0);
        @(negedge clk);
        chk("umul_done_1cyc", done32, 0);

        // Signed -7 / 2
        go32(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
        chk("sdiv_lat", lat, 34);
        chk("sdiv_lo", lo32, 32'hFFFF_FFFD);
        chk("sdiv_hi", hi32, 32'hFFFF_FFFF);
        chk("sdiv_div0", div0_32, 0);

        // Signed -3 * 5
        go32(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, lat);
        chk("smul_hi", hi32, 32'hFFFF_FFFF);
        chk("smul_lo", lo32, 32'hFFFF_FFF1);

        // Unsigned 0x2211 / 0x100 leaves hi=0x11, lo=0x22
        go32(1'b1, 1'b0, 32'h0000_2211, 32'h0000_0100, lat);
        chk("udiv_hi", hi32, 32'h11);
        chk("udiv_lo", lo32, 32'h22);

        // Divide by zero keeps previous results
        go32(1'b1, 1'b0, 32'd5, 32'd0, lat);
        chk("dz_lat", lat, 1);
        chk("dz_div0", div0_32, 1);
        chk("dz_hi", hi32, 32'h11);
        chk("dz_lo", lo32, 32'h22);

        // Most-negative / -1 wraps
        go32(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("wrap_lat", lat, 34);
        chk("wrap_lo", lo32, 32'h8000_0000);
        chk("wrap_hi", hi32, 32'h0);
        chk("wrap_div0", div0_32, 0);

        // Flush in RUN aborts with no done and untouched outputs
        @(negedge clk);
        op32 = 1'b0; sgn32 = 1'b0; a32 = 32'd3; b32 = 32'd4; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        chk("flush_busy", busy32, 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        chk("flush_no_done", ndone, 0);
        chk("flush_hi", hi32, 32'h0);
        chk("flush_lo", lo32, 32'h8000_0000);
        chk("flush_div0", div0_32, 0);

        // Start during RUN is ignored; flush with start in IDLE still starts
        @(negedge clk);
        op32 = 1'b0; sgn32 = 1'b0; a32 = 32'd6; b32 = 32'd7; start32 = 1'b1; flush32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0; flush32 = 1'b0;
        repeat (5) @(negedge clk);
        a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        chk("ign_single_done", ndone, 1);
        chk("ign_hi", hi32, 32'h0);
        chk("ign_lo", lo32, 32'd42);

        // WIDTH=8: unsigned 200 / 7
        @(negedge clk);
        op8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_lat", lat, 10);
        chk("w8_lo", lo8, 8'd28);
        chk("w8_hi", hi8, 8'd4);

        // WIDTH=8: reset mid-RUN clears everything, no done
        @(negedge clk);
        op8 = 1'b0; a8 = 8'd15; b8 = 8'd15; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset8 = 1'b1;
        @(negedge clk);
        reset8 = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("w8_rst_no_done", ndone, 0);
        chk("w8_rst_busy", busy8, 0);
        chk("w8_rst_div0", div0_8, 0);
        chk("w8_rst_hi", hi8, 0);
        chk("w8_rst_lo", lo8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; the legal range SHALL be 4..64.
REQ-002 Ports SHALL be (clock and reset first):
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  1  0 = multiply, 1 = divide.
- sgn  input  1  1 = signed two's-complement, 0 = unsigned.
- a  input  WIDTH  multiplicand or dividend.
- b  input  WIDTH  multiplier or divisor.
- flush  input  1  synchronous abort of the operation in flight.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- div0  output  1  divide-by-zero flag for the last completed operation.
- hi  output  WIDTH  upper product half, or remainder.
- lo  output  WIDTH  lower product half, or quotient.

Function
REQ-003 The FSM SHALL have four states: IDLE, RUN, FIX, DONE.
REQ-004 IDLE with start=1 SHALL latch op, sgn and the operand magnitudes (|a|, |b| when sgn=1, raw otherwise) plus the result sign bits.
REQ-005 The FSM SHALL then enter RUN and load the iteration counter with WIDTH-1.
REQ-006 RUN SHALL perform exactly one radix-2 step per cycle (shift-add for multiply, restoring subtract for divide) for WIDTH cycles, then enter FIX.
REQ-007 FIX SHALL apply sign correction and write hi/lo, then enter DONE.
- Multiply: negate the 2*WIDTH-bit product if sign(a) XOR sign(b).
- Divide: negate the quotient if sign(a) XOR sign(b); give the remainder the sign of a.
REQ-008 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-009 Latency for a start sampled at edge t: done=1 in the cycle following edge t+WIDTH+2; hi/lo valid in that same cycle.
REQ-010 A divide with b==0 at start SHALL skip RUN and FIX and go IDLE->DONE.
- done=1 in the cycle following edge t+1.
- div0=1; hi/lo keep their previous values.
REQ-011 div0 SHALL be updated only in DONE: 1 for a divide-by-zero, 0 for any other operation.
REQ-012 hi, lo and div0 SHALL hold their values between completions; a new start SHALL NOT disturb them before its own DONE.
REQ-013 start while busy=1 SHALL be ignored; no queuing.
REQ-014 Signed divide of the most-negative value by -1 SHALL wrap: lo = 2^(WIDTH-1) pattern, hi = 0, div0 = 0, no trap.
REQ-015 Unsigned results SHALL equal the exact 2*WIDTH-bit product, or floor quotient and remainder.
REQ-016 flush=1 in RUN or FIX SHALL return the FSM to IDLE on the next edge.
- No done pulse is issued; hi/lo/div0 are unchanged.
REQ-017 flush in IDLE or DONE SHALL have no effect; a DONE pulse is never suppressed.
REQ-018 flush and start asserted together in IDLE SHALL start a new operation (flush ignored).
REQ-019 All outputs SHALL be driven from registers; there is no combinational path from any input to any output.

Reset
REQ-020 reset=1 SHALL take priority over flush and start.
REQ-021 reset SHALL force IDLE, busy=0, done=0, div0=0, hi=0, lo=0 and counter=0 on the next edge.
REQ-022 reset asserted mid-RUN SHALL discard the operation and issue no done pulse.

Verification (WIDTH=32 unless stated)
REQ-023 Unsigned multiply: a=0xFFFFFFFF, b=0xFFFFFFFF, start -> done in cycle after edge t+34; hi=0xFFFFFFFE, lo=0x00000001.
REQ-024 Signed divide: a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div0=0; signed multiply -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-025 Divide by zero: a=5, b=0 with prior hi/lo=0x11/0x22 -> done in cycle after edge t+1, div0=1, hi=0x11, lo=0x22.
REQ-026 Wrap case: sgn=1, a=0x80000000, b=0xFFFFFFFF divide -> lo=0x80000000, hi=0, div0=0.
REQ-027 Abort: flush at RUN cycle 10 -> IDLE next edge, no done, outputs unchanged; start pulsed during RUN -> ignored, single done only.
REQ-028 WIDTH=8 instance: unsigned 200/7 -> lo=28, hi=4, done in cycle after edge t+10; reset mid-RUN -> all outputs 0, no done.
